z_slice_buf: RTL and testbench

Parametrised successor to the datapath Z result register. Captures wide ALU results (e.g. MUL/DIV products) into a DEPTH-entry queue and returns them on the BUS_W-wide bus one slice at a time. Two modes:
- Manual mode: the control unit picks the slice and releases the entry explicitly.
- Auto mode: a valid/ready handshake drains the slices low-to-high.

The block sits between the ALU output and the internal bus.

---
 rtl/z_buf_pkg.sv | 19 +
 rtl/z_slice_mux.sv | 31 +++
 rtl/z_slice_buf.sv | 140 ++++++++++++++
 tb/tb_z_slice_buf.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/z_buf_pkg.sv
// Shared definitions for the Z slice buffer.
//   MODE_MANUAL / MODE_AUTO : encoding of the mode input
//   seq_state_e             : auto-mode sequencer states
//   idx_w()                 : width of an index over n items (at least 1 bit)
package z_buf_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } seq_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/z_slice_mux.sv
// Selects one BUS_W-wide slice out of a BUS_W*SLICES entry.
//   entry : wide entry, slice 0 = bits BUS_W-1:0
//   idx   : slice index
//   en    : output is forced to 0 when low
//   slice : selected slice, 0 when disabled or idx >= SLICES
module z_slice_mux
  import z_buf_pkg::*;
#(
  parameter  int BUS_W  = 32,
  parameter  int SLICES = 2,
  localparam int SEL_W  = idx_w(SLICES)
) (
  input  logic [BUS_W*SLICES-1:0] entry,
  input  logic [SEL_W-1:0]        idx,
  input  logic                    en,
  output logic [BUS_W-1:0]        slice
);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    slice = '0;
    if (en) begin
      for (int i = 0; i < SLICES; i++) begin
        // Indices with no matching slice fall through to the zero default.
        if (idx == SEL_W'(i)) slice = entry[i*BUS_W +: BUS_W];
      end
    end
  end

endmodule

// File: rtl/z_slice_buf.sv
// Z result queue: captures wide ALU results and returns them one bus-wide
// slice at a time, either under explicit control (manual) or through a
// valid/ready handshake that drains slices low-to-high (auto).
//   clk, clr           : clock (rising edge), async active-low reset
//   D, ZIn             : wide write data and write strobe
//   mode               : 0 manual, 1 auto
//   sel_out, slice_sel : manual read enable and slice index
//   pop                : manual release of the head entry
//   z_ready            : auto-mode consumer acceptance
//   ovf_clr            : clears the sticky overflow flag
//   Z, z_valid, z_last : slice output, valid, last slice of entry (auto)
//   wr_ready, count    : queue not full, occupied entries
//   ovf                : sticky dropped-write flag
module z_slice_buf
  import z_buf_pkg::*;
#(
  parameter  int BUS_W   = 32,
  parameter  int SLICES  = 2,
  parameter  int DEPTH   = 2,
  localparam int ENTRY_W = BUS_W * SLICES,
  localparam int SEL_W   = idx_w(SLICES),
  localparam int PTR_W   = idx_w(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [ENTRY_W-1:0] D,
  input  logic               ZIn,
  input  logic               mode,
  input  logic               sel_out,
  input  logic [SEL_W-1:0]   slice_sel,
  input  logic               pop,
  input  logic               z_ready,
  input  logic               ovf_clr,
  output logic [BUS_W-1:0]   Z,
  output logic               z_valid,
  output logic               z_last,
  output logic               wr_ready,
  output logic [CNT_W-1:0]   count,
  output logic               ovf
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic [SEL_W-1:0]   slice_idx, slice_idx_nxt;
  seq_state_e         state, state_nxt;
  logic               ovf_q;

  logic               is_empty, is_full, is_auto, at_last;
  logic               rd_en, do_rel, do_wr, drop;
  logic [SEL_W-1:0]   rd_idx;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_auto  = (mode == MODE_AUTO);
  assign at_last  = (slice_idx == SEL_W'(SLICES - 1));

  // Read control, release/write decisions and sequencer next state.
  always_comb begin
    rd_en         = 1'b0;
    rd_idx        = '0;
    z_last        = 1'b0;
    do_rel        = 1'b0;
    count_nxt     = count_q;
    slice_idx_nxt = '0;
    state_nxt     = state;

    if (is_auto) begin
      rd_en  = (state == ST_DRAIN);
      rd_idx = slice_idx;
      z_last = rd_en & at_last;
      do_rel = rd_en & z_ready & at_last;
      // Back-pressure holds the slice; a handshake advances or wraps it.
      slice_idx_nxt = slice_idx;
      if (rd_en && z_ready) slice_idx_nxt = at_last ? '0 : slice_idx + SEL_W'(1);
    end else begin
      // Manual mode restarts any partial auto drain at slice 0.
      rd_en  = sel_out & ~is_empty;
      rd_idx = slice_sel;
      do_rel = pop & ~is_empty;
    end

    // A full queue still accepts a write when the head leaves on the same edge.
    do_wr = ZIn & (~is_full | do_rel);
    drop  = ZIn & ~do_wr;

    case ({do_wr, do_rel})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase

    state_nxt = (count_nxt != '0) ? ST_DRAIN : ST_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the storage array is reset too, so a reset mid-drain leaves no
  // stale data that a later pointer wrap could expose.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      slice_idx <= '0;
      state     <= ST_EMPTY;
      ovf_q     <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= D;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_rel) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q   <= count_nxt;
      slice_idx <= slice_idx_nxt;
      state     <= state_nxt;
      // A drop on the same edge as a clear leaves the flag set.
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  z_slice_mux #(
    .BUS_W  (BUS_W),
    .SLICES (SLICES)
  ) u_mux (
    .entry (mem[rd_ptr]),
    .idx   (rd_idx),
    .en    (rd_en),
    .slice (Z)
  );

  assign z_valid  = rd_en;
  assign wr_ready = ~is_full;
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_z_slice_buf.sv
// Directed self-checking bench for z_slice_buf (BUS_W=32, SLICES=2, DEPTH=2).
// Expected slices are queued when an entry is written and popped as the
// design presents them.
module tb_z_slice_buf;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] D = '0;
  logic        ZIn = 1'b0;
  logic        mode = 1'b0;
  logic        sel_out = 1'b0;
  logic [0:0]  slice_sel = '0;
  logic        pop = 1'b0;
  logic        z_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] Z;
  logic        z_valid, z_last, wr_ready, ovf;
  logic [1:0]  count;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_z;

  z_slice_buf #(.BUS_W(32), .SLICES(2), .DEPTH(2)) dut (
    .clk       (clk),
    .clr       (clr),
    .D         (D),
    .ZIn       (ZIn),
    .mode      (mode),
    .sel_out   (sel_out),
    .slice_sel (slice_sel),
    .pop       (pop),
    .z_ready   (z_ready),
    .ovf_clr   (ovf_clr),
    .Z         (Z),
    .z_valid   (z_valid),
    .z_last    (z_last),
    .wr_ready  (wr_ready),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] d, input bit keep);
    D   = d;
    ZIn = 1'b1;
    tick();
    ZIn = 1'b0;
    if (keep) begin
      sb.push_back(d[31:0]);
      sb.push_back(d[63:32]);
    end
  endtask

  // Auto-mode drain with z_ready held high; whole entries remain in sb.
  task automatic drain_all();
    int exp_slice = 0;
    logic [31:0] e;
    mode    = 1'b1;
    z_ready = 1'b1;
    #1;
    for (int n = 0; n < 64 && sb.size() != 0; n++) begin
      e = sb.pop_front();
      check("drain_valid", z_valid, 1);
      check("drain_z", Z, e);
      check("drain_last", z_last, (exp_slice == 1));
      exp_slice = (exp_slice + 1) % 2;
      tick();
    end
    check("drain_left", sb.size(), 0);
    z_ready = 1'b0;
    #1;
    check("drain_end_valid", z_valid, 0);
    check("drain_end_count", count, 0);
  endtask

  initial begin
    // 1. Asynchronous reset before any clock edge.
    #3;
    check("rst_z", Z, 0);
    check("rst_valid", z_valid, 0);
    check("rst_last", z_last, 0);
    check("rst_count", count, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_ovf", ovf, 0);
    #1 clr = 1'b1;
    tick();

    // 2. Manual read of both slices, then release.
    wr(64'h1111_2222_3333_4444, 1);
    mode = 1'b0; sel_out = 1'b0; #1;
    check("man_nosel_valid", z_valid, 0);
    check("man_nosel_z", Z, 0);
    sel_out = 1'b1; slice_sel = 1'b0; #1;
    exp_z = sb.pop_front();
    check("man_valid", z_valid, 1);
    check("man_s0", Z, exp_z);
    check("man_last", z_last, 0);
    slice_sel = 1'b1; #1;
    exp_z = sb.pop_front();
    check("man_s1", Z, exp_z);
    check("man_count1", count, 1);
    pop = 1'b1; tick(); pop = 1'b0;
    check("man_pop_count", count, 0);
    check("man_pop_z", Z, 0);
    check("man_pop_valid", z_valid, 0);
    // Pop on an empty queue alongside a write: only the write takes effect.
    D = 64'h5555_6666_7777_8888; ZIn = 1'b1; pop = 1'b1;
    tick();
    ZIn = 1'b0; pop = 1'b0; slice_sel = 1'b0; #1;
    check("man_wr_pop_empty_count", count, 1);
    check("man_wr_pop_empty_z", Z, 32'h7777_8888);
    pop = 1'b1; tick(); pop = 1'b0;
    check("man_clear_count", count, 0);
    sel_out = 1'b0;

    // 3. Auto drain with back-pressure.
    wr(64'hAAAA_0001_BBBB_0002, 1);
    wr(64'hCCCC_0003_DDDD_0004, 1);
    mode = 1'b1; z_ready = 1'b0; #1;
    check("auto_first_z", Z, sb[0]);
    check("auto_first_last", z_last, 0);
    check("auto_first_valid", z_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("auto_hold_z", Z, sb[0]);
      check("auto_hold_last", z_last, 0);
    end
    drain_all();

    // 4. Overflow: third write dropped; clear, set-wins, clear again.
    mode = 1'b0;
    wr(64'h0000_0011_0000_0022, 1);
    wr(64'h0000_0033_0000_0044, 1);
    wr(64'hDEAD_BEEF_DEAD_BEEF, 0);
    check("ovf_count", count, 2);
    check("ovf_wr_ready", wr_ready, 0);
    check("ovf_set", ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);
    D = 64'hDEAD_BEEF_DEAD_BEEF; ZIn = 1'b1; ovf_clr = 1'b1;
    tick();
    ZIn = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared2", ovf, 0);
    drain_all();

    // 5. Full queue: last-slice handshake and write on the same edge.
    mode = 1'b1; z_ready = 1'b0;
    wr(64'h1000_0001_2000_0002, 1);
    wr(64'h3000_0003_4000_0004, 1);
    check("full_count", count, 2);
    check("full_wr_ready", wr_ready, 0);
    exp_z = sb.pop_front();
    check("full_s0", Z, exp_z);
    z_ready = 1'b1; tick(); z_ready = 1'b0;
    exp_z = sb.pop_front();
    check("full_s1", Z, exp_z);
    check("full_s1_last", z_last, 1);
    D = 64'h5000_0005_6000_0006; ZIn = 1'b1; z_ready = 1'b1;
    tick();
    ZIn = 1'b0; z_ready = 1'b0;
    sb.push_back(32'h6000_0006);
    sb.push_back(32'h5000_0005);
    check("full_rel_count", count, 2);
    check("full_rel_ovf", ovf, 0);
    drain_all();

    // 6. Reset mid-drain, then mode switch restarting a partial drain.
    mode = 1'b1; z_ready = 1'b0;
    wr(64'h7000_0007_8000_0008, 1);
    check("mid_s0", Z, sb[0]);
    z_ready = 1'b1; tick(); z_ready = 1'b0;
    check("mid_s1", Z, sb[1]);
    #1 clr = 1'b0;
    #1;
    check("mid_rst_z", Z, 0);
    check("mid_rst_valid", z_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_wr_ready", wr_ready, 1);
    clr = 1'b1;
    sb.delete();
    tick();
    wr(64'h9000_0009_A000_000A, 1);
    check("post_rst_s0", Z, sb[0]);
    check("post_rst_last", z_last, 0);
    z_ready = 1'b1; tick(); z_ready = 1'b0;
    check("switch_s1", Z, sb[1]);
    mode = 1'b0; tick();
    mode = 1'b1; #1;
    check("switch_restart_z", Z, sb[0]);
    check("switch_restart_last", z_last, 0);
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
